mem_dualport: RTL and testbench

Lane-parallel register-file memory for the GPU mini-shader datapath, shared by all SIMD lanes. Each lane has one synchronous write port and two asynchronous read ports (A and B), so one cycle can fetch two operands per lane and write back one result per lane. It sits between the lane ALUs and the operand/writeback stages of the shader core.

---
 rtl/mem_dualport_pkg.sv | 10 +
 rtl/mem_dualport.sv | 76 +++++++
 tb/tb_mem_dualport.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dualport_pkg.sv
// Shared shader-core types: lane count, register-file depth, word type.
// Imported by the lane-parallel register-file memory.
package GPU_Shader_pkg;

  localparam int lanes     = 4;
  localparam int MEM_DEPTH = 256;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_dualport.sv
// Lane-parallel register file: per-lane 1W/2R, async reads, sync writes.
// Optional wr_conflict output enabled by MEM_DUALPORT_CONFLICT_EN.
module mem_dualport
  import GPU_Shader_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [lanes-1:0]      write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr  [lanes],
  input  word_t                 write_data  [lanes],
  input  logic [ADDR_WIDTH-1:0] read_addr_a [lanes],
  output word_t                 read_data_a [lanes],
  input  logic [ADDR_WIDTH-1:0] read_addr_b [lanes],
  output word_t                 read_data_b [lanes]
`ifdef MEM_DUALPORT_CONFLICT_EN
  ,
  output logic                  wr_conflict
`endif
);

  word_t mem [MEM_DEPTH];

  function automatic logic in_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    return 64'(a) < 64'(MEM_DEPTH);
  endfunction

  // Clear on reset; otherwise commit lanes in ascending order so the
  // highest enabled lane wins a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < MEM_DEPTH; j++) begin
        mem[j] <= '0;
      end
    end else begin
      for (int i = 0; i < lanes; i++) begin
        if (write_en[i] && in_range(write_addr[i])) begin
          mem[write_addr[i]] <= write_data[i];
        end
      end
    end
  end

  // Combinational reads; out-of-range addresses return zero.
  always_comb begin
    for (int i = 0; i < lanes; i++) begin
      read_data_a[i] = '0;
      read_data_b[i] = '0;
      if (in_range(read_addr_a[i])) begin
        read_data_a[i] = mem[read_addr_a[i]];
      end
      if (in_range(read_addr_b[i])) begin
        read_data_b[i] = mem[read_addr_b[i]];
      end
    end
  end

`ifdef MEM_DUALPORT_CONFLICT_EN
  // Flag any pair of enabled lanes aiming at the same address.
  always_comb begin
    wr_conflict = 1'b0;
    for (int i = 0; i < lanes; i++) begin
      for (int j = i + 1; j < lanes; j++) begin
        if (write_en[i] && write_en[j] &&
            write_addr[i] == write_addr[j]) begin
          wr_conflict = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_dualport.sv
// Self-checking bench for mem_dualport against a behavioural array model.
// Build with MEM_DUALPORT_CONFLICT_EN to also check wr_conflict.
module tb_mem_dualport;
  import GPU_Shader_pkg::*;

  localparam int AW = $clog2(MEM_DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [lanes-1:0] write_en;
  logic [AW-1:0]    write_addr  [lanes];
  word_t            write_data  [lanes];
  logic [AW-1:0]    read_addr_a [lanes];
  word_t            read_data_a [lanes];
  logic [AW-1:0]    read_addr_b [lanes];
  word_t            read_data_b [lanes];
`ifdef MEM_DUALPORT_CONFLICT_EN
  logic             wr_conflict;
`endif

  int vectors = 0;
  int miscompares = 0;

  word_t model [MEM_DEPTH];

  always #5 clk = ~clk;

  mem_dualport dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr_a (read_addr_a),
    .read_data_a (read_data_a),
    .read_addr_b (read_addr_b),
    .read_data_b (read_data_b)
`ifdef MEM_DUALPORT_CONFLICT_EN
    ,
    .wr_conflict (wr_conflict)
`endif
  );

  function automatic word_t mref(input int a);
    return (a < MEM_DEPTH) ? model[a] : 32'd0;
  endfunction

  function automatic logic conflict_ref();
    for (int i = 0; i < lanes; i++)
      for (int j = 0; j < lanes; j++)
        if (i != j && write_en[i] && write_en[j] &&
            write_addr[i] == write_addr[j])
          return 1'b1;
    return 1'b0;
  endfunction

  // Advance one rising edge, applying the write rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j < MEM_DEPTH; j++) model[j] = '0;
    end else begin
      for (int i = 0; i < lanes; i++)
        if (write_en[i]) model[int'(write_addr[i])] = write_data[i];
    end
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    rst = 1'b0;
    write_en = '0;
    for (int i = 0; i < lanes; i++) begin
      write_addr[i] = '0;
      write_data[i] = '0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    write_en = '0;
    tick();
    idle();
    read_addr_a[0] = 8'd0;   read_addr_b[0] = 8'd4;
    read_addr_a[1] = 8'd255; read_addr_b[1] = 8'd0;
    read_addr_a[2] = 8'd4;   read_addr_b[2] = 8'd255;
    read_addr_a[3] = 8'd255; read_addr_b[3] = 8'd4;
    #1;
    for (int l = 0; l < lanes; l++) begin
      vectors++;
      if (read_data_a[l] !== 32'd0 || read_data_b[l] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset lane%0d a=%0h b=%0h want 0",
                 l, read_data_a[l], read_data_b[l]);
      end
    end
  endtask

  task automatic test_parallel_write();
    @(negedge clk);
    for (int l = 0; l < lanes; l++) begin
      write_en[l]    = 1'b1;
      write_addr[l]  = AW'(4 + l);
      write_data[l]  = 32'(100 + l);
      read_addr_a[l] = AW'(4 + l);
      read_addr_b[l] = AW'(4 + l);
    end
    #1;
    for (int l = 0; l < lanes; l++) begin
      vectors++;
      if (read_data_a[l] !== 32'd0 || read_data_b[l] !== 32'd0) begin
        miscompares++;
        $display("FAIL rbw lane%0d a=%0d b=%0d want 0",
                 l, read_data_a[l], read_data_b[l]);
      end
    end
    tick();
    for (int l = 0; l < lanes; l++) begin
      vectors++;
      if (read_data_a[l] !== 32'(100 + l) ||
          read_data_b[l] !== 32'(100 + l)) begin
        miscompares++;
        $display("FAIL pwrite lane%0d a=%0d b=%0d want %0d",
                 l, read_data_a[l], read_data_b[l], 100 + l);
      end
    end
    idle();
  endtask

  task automatic test_conflict();
    @(negedge clk);
    write_en = 4'b0011;
    write_addr[0] = 8'd5; write_data[0] = 32'd555;
    write_addr[1] = 8'd5; write_data[1] = 32'd999;
    read_addr_a[2] = 8'd5;
    read_addr_b[2] = 8'd5;
    #1;
    vectors++;
    if (read_data_a[2] !== 32'd101 || read_data_b[2] !== 32'd101) begin
      miscompares++;
      $display("FAIL conflict_pre a=%0d b=%0d want 101",
               read_data_a[2], read_data_b[2]);
    end
`ifdef MEM_DUALPORT_CONFLICT_EN
    vectors++;
    if (wr_conflict !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_conflict_hi got %b want 1", wr_conflict);
    end
`endif
    tick();
    vectors++;
    if (read_data_a[2] !== 32'd999 || read_data_b[2] !== 32'd999) begin
      miscompares++;
      $display("FAIL conflict_post a=%0d b=%0d want 999",
               read_data_a[2], read_data_b[2]);
    end
    idle();
`ifdef MEM_DUALPORT_CONFLICT_EN
    #1;
    vectors++;
    if (wr_conflict !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_conflict_lo got %b want 0", wr_conflict);
    end
`endif
  endtask

  task automatic test_cross_lane();
    @(negedge clk);
    read_addr_a[3] = 8'd4;
    read_addr_b[0] = 8'd7;
    #1;
    vectors++;
    if (read_data_a[3] !== 32'd100) begin
      miscompares++;
      $display("FAIL cross_a3 got %0d want 100", read_data_a[3]);
    end
    vectors++;
    if (read_data_b[0] !== 32'd103) begin
      miscompares++;
      $display("FAIL cross_b0 got %0d want 103", read_data_b[0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    write_en = 4'b0001;
    write_addr[0] = 8'd10;
    write_data[0] = 32'd77;
    tick();
    idle();
    read_addr_a[0] = 8'd10;
    read_addr_b[0] = 8'd10;
    for (int l = 1; l < lanes; l++) begin
      read_addr_a[l] = AW'(3 + l);
      read_addr_b[l] = AW'(4 + l);
    end
    #1;
    for (int l = 0; l < lanes; l++) begin
      vectors++;
      if (read_data_a[l] !== 32'd0 || read_data_b[l] !== 32'd0) begin
        miscompares++;
        $display("FAIL rst_mid lane%0d a=%0d b=%0d want 0",
                 l, read_data_a[l], read_data_b[l]);
      end
    end
  endtask

  task automatic test_disabled();
    @(negedge clk);
    write_en = '0;
    write_addr[0] = 8'd8;
    write_data[0] = 32'd42;
    read_addr_a[1] = 8'd8;
    tick();
    vectors++;
    if (read_data_a[1] !== 32'd0) begin
      miscompares++;
      $display("FAIL disabled got %0d want 0", read_data_a[1]);
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      for (int l = 0; l < lanes; l++) begin
        write_en[l]    = $urandom_range(0, 1) == 1;
        write_addr[l]  = (c % 2 == 0) ? AW'($urandom_range(0, 7))
                                      : AW'($urandom);
        write_data[l]  = $urandom;
        read_addr_a[l] = (c % 3 == 0) ? write_addr[l] : AW'($urandom_range(0, 15));
        read_addr_b[l] = AW'($urandom);
      end
      #1;
      for (int l = 0; l < lanes; l++) begin
        vectors++;
        if (read_data_a[l] !== mref(int'(read_addr_a[l])) ||
            read_data_b[l] !== mref(int'(read_addr_b[l]))) begin
          miscompares++;
          $display("FAIL rand c%0d lane%0d a=%0h/%0h b=%0h/%0h", c, l,
                   read_data_a[l], mref(int'(read_addr_a[l])),
                   read_data_b[l], mref(int'(read_addr_b[l])));
        end
      end
`ifdef MEM_DUALPORT_CONFLICT_EN
      vectors++;
      if (wr_conflict !== conflict_ref()) begin
        miscompares++;
        $display("FAIL rand_conflict c%0d got %b want %b",
                 c, wr_conflict, conflict_ref());
      end
`endif
      tick();
      for (int l = 0; l < lanes; l++) begin
        vectors++;
        if (read_data_a[l] !== mref(int'(read_addr_a[l]))) begin
          miscompares++;
          $display("FAIL rand_post c%0d lane%0d got %0h want %0h", c, l,
                   read_data_a[l], mref(int'(read_addr_a[l])));
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    write_en = '0;
    for (int i = 0; i < lanes; i++) begin
      write_addr[i]  = '0;
      write_data[i]  = '0;
      read_addr_a[i] = '0;
      read_addr_b[i] = '0;
    end
    for (int j = 0; j < MEM_DEPTH; j++) model[j] = '0;
    test_reset();
    test_parallel_write();
    test_conflict();
    test_cross_lane();
    test_reset_mid();
    test_disabled();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
